// File: rtl/adc_scan_sequencer.sv
// ADC scan sequencer: converts the enabled channels in ascending order and queues
// channel-tagged results in a first-word-fall-through FIFO for the host to drain.
module adc_scan_sequencer #(
  parameter int N_CHAN      = 4,
  parameter int DATA_W      = 12,
  parameter int FIFO_DEPTH  = 16,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic                               clk_clk,
  input  logic                               reset_reset_n,
  input  logic                               i_start,
  input  logic                               i_stop,
  input  logic                               i_mode,
  input  logic [N_CHAN-1:0]                  i_chan_mask,
  output logic                               o_adc_req,
  output logic [$clog2(N_CHAN)-1:0]          o_adc_chan,
  input  logic                               i_adc_valid,
  input  logic [DATA_W-1:0]                  i_adc_data,
  input  logic                               i_rd_en,
  output logic [$clog2(N_CHAN)+DATA_W-1:0]   o_rd_data,
  output logic                               o_empty,
  output logic                               o_full,
  output logic [$clog2(FIFO_DEPTH):0]        o_level,
  output logic                               o_busy,
  output logic                               o_overflow,
  output logic                               o_timeout,
  input  logic                               i_clr_flags
);
  localparam int CH_W  = $clog2(N_CHAN);
  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam int ENT_W = CH_W + DATA_W;
  localparam int CNT_W = $clog2(TIMEOUT_CYC) + 1;
  localparam logic [N_CHAN-1:0] ONE_M = {{(N_CHAN-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {IDLE = 2'd0, ARM = 2'd1, CONV = 2'd2, NEXT = 2'd3} state_t;

  state_t             state_r;
  logic [N_CHAN-1:0]  mask_r;
  logic               mode_r;
  logic               stop_r;
  logic [CH_W-1:0]    chan_r;
  logic [CNT_W-1:0]   cnt_r;
  logic               req_r;
  logic               busy_r;
  logic               ovf_r;
  logic               tout_r;
  logic [ENT_W-1:0]   mem_r [FIFO_DEPTH];
  logic [AW-1:0]      wr_ptr_r;
  logic [AW-1:0]      rd_ptr_r;
  logic [AW:0]        level_r;
  logic [AW:0]        level_nxt_s;
  logic               empty_r;
  logic               full_r;
  logic [N_CHAN-1:0]  hi_mask_s;
  logic               last_cnt_s;
  logic               wr_req_s;
  logic               wr_ok_s;
  logic               rd_ok_s;
  logic               drop_s;
  logic               tout_set_s;

  function automatic logic [CH_W-1:0] lowest_chan(input logic [N_CHAN-1:0] m);
    lowest_chan = '0;
    for (int i = N_CHAN - 1; i >= 0; i--) begin
      if (m[i]) lowest_chan = CH_W'(i);
    end
  endfunction

  // Channels strictly above the current one; the shift overflows to zero for the top channel.
  assign hi_mask_s  = mask_r & ~(((ONE_M << chan_r) << 1'b1) - ONE_M);
  assign last_cnt_s = (cnt_r == CNT_W'(TIMEOUT_CYC - 1));
  assign wr_req_s   = (state_r == CONV) && i_adc_valid;
  assign rd_ok_s    = i_rd_en && !empty_r;
  assign wr_ok_s    = wr_req_s && (!full_r || i_rd_en);
  assign drop_s     = wr_req_s && full_r && !i_rd_en;
  assign tout_set_s = (state_r == CONV) && !i_adc_valid && last_cnt_s;

  // Scan control FSM with registered request, channel and busy outputs.
  always_ff @(posedge clk_clk) begin
    if (!reset_reset_n) begin
      state_r <= IDLE;
      mask_r  <= '0;
      mode_r  <= 1'b0;
      stop_r  <= 1'b0;
      chan_r  <= '0;
      cnt_r   <= '0;
      req_r   <= 1'b0;
      busy_r  <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          stop_r <= 1'b0;
          if (i_start && (|i_chan_mask)) begin
            mask_r  <= i_chan_mask;
            mode_r  <= i_mode;
            busy_r  <= 1'b1;
            state_r <= ARM;
          end
        end
        ARM: begin
          if (i_stop) stop_r <= 1'b1;
          chan_r  <= lowest_chan(mask_r);
          cnt_r   <= '0;
          req_r   <= 1'b1;
          state_r <= CONV;
        end
        CONV: begin
          if (i_stop) stop_r <= 1'b1;
          if (i_adc_valid || last_cnt_s) begin
            req_r   <= 1'b0;
            state_r <= NEXT;
          end else begin
            cnt_r <= cnt_r + CNT_W'(1);
          end
        end
        NEXT: begin
          if (stop_r || i_stop) begin
            stop_r  <= 1'b0;
            busy_r  <= 1'b0;
            state_r <= IDLE;
          end else if (|hi_mask_s) begin
            chan_r  <= lowest_chan(hi_mask_s);
            cnt_r   <= '0;
            req_r   <= 1'b1;
            state_r <= CONV;
          end else if (mode_r && (|i_chan_mask)) begin
            mask_r  <= i_chan_mask;
            state_r <= ARM;
          end else begin
            busy_r  <= 1'b0;
            state_r <= IDLE;
          end
        end
        default: begin
          req_r   <= 1'b0;
          busy_r  <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

  // Next FIFO occupancy from the accepted write/read pair.
  always_comb begin
    level_nxt_s = level_r;
    if (wr_ok_s && !rd_ok_s) begin
      level_nxt_s = level_r + {{AW{1'b0}}, 1'b1};
    end else if (rd_ok_s && !wr_ok_s) begin
      level_nxt_s = level_r - {{AW{1'b0}}, 1'b1};
    end else begin
      level_nxt_s = level_r;
    end
  end

  // Result FIFO storage, pointers and status.
  always_ff @(posedge clk_clk) begin
    if (!reset_reset_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem_r[i] <= '0;
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      level_r  <= '0;
      empty_r  <= 1'b1;
      full_r   <= 1'b0;
    end else begin
      if (wr_ok_s) begin
        mem_r[wr_ptr_r] <= {chan_r, i_adc_data};
        wr_ptr_r        <= wr_ptr_r + {{(AW-1){1'b0}}, 1'b1};
      end
      if (rd_ok_s) rd_ptr_r <= rd_ptr_r + {{(AW-1){1'b0}}, 1'b1};
      level_r <= level_nxt_s;
      empty_r <= (level_nxt_s == '0);
      full_r  <= (level_nxt_s == (AW+1)'(FIFO_DEPTH));
    end
  end

  // Sticky error flags; a same-cycle set takes priority over clear.
  always_ff @(posedge clk_clk) begin
    if (!reset_reset_n) begin
      ovf_r  <= 1'b0;
      tout_r <= 1'b0;
    end else begin
      ovf_r  <= drop_s     | (ovf_r  & ~i_clr_flags);
      tout_r <= tout_set_s | (tout_r & ~i_clr_flags);
    end
  end

  assign o_adc_req  = req_r;
  assign o_adc_chan = chan_r;
  assign o_busy     = busy_r;
  assign o_rd_data  = mem_r[rd_ptr_r];
  assign o_empty    = empty_r;
  assign o_full     = full_r;
  assign o_level    = level_r;
  assign o_overflow = ovf_r;
  assign o_timeout  = tout_r;
endmodule

// File: tb/tb_adc_scan_sequencer.sv
// Self-checking bench for adc_scan_sequencer: an ADC responder pushes expected
// FIFO entries to a scoreboard queue; pops from the DUT are compared against it.
module tb_adc_scan_sequencer;
  localparam int N_CHAN = 4, DATA_W = 12, FIFO_DEPTH = 16, TIMEOUT_CYC = 1024;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start, stop, mode, clr_flags, rd_en;
  logic [3:0]  chan_mask;
  logic        adc_req, adc_valid;
  logic [1:0]  adc_chan;
  logic [11:0] adc_data;
  logic [13:0] rd_data;
  logic        empty, full, busy, ovf, tout;
  logic [4:0]  level;

  adc_scan_sequencer #(.N_CHAN(N_CHAN), .DATA_W(DATA_W), .FIFO_DEPTH(FIFO_DEPTH),
                       .TIMEOUT_CYC(TIMEOUT_CYC)) dut (
    .clk_clk(clk), .reset_reset_n(rst_n), .i_start(start), .i_stop(stop),
    .i_mode(mode), .i_chan_mask(chan_mask), .o_adc_req(adc_req), .o_adc_chan(adc_chan),
    .i_adc_valid(adc_valid), .i_adc_data(adc_data), .i_rd_en(rd_en), .o_rd_data(rd_data),
    .o_empty(empty), .o_full(full), .o_level(level), .o_busy(busy),
    .o_overflow(ovf), .o_timeout(tout), .i_clr_flags(clr_flags)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [13:0] exp_q[$];
  int          mdl_cnt = 0;
  logic        exp_ovf = 1'b0;
  logic        resp_en = 1'b0;
  logic        vary = 1'b0;
  logic [3:0]  silent = 4'b0000;
  int          resp_delay = 5;
  int          seq = 0;
  int          n_valid = 0;
  logic [11:0] tab [4];

  // Request monitor: rising edges, ch3 requests, cycles spent requesting ch1.
  int   req_pulses = 0, ch3_reqs = 0, ch1_len = 0;
  logic prev_req = 1'b0;
  always @(negedge clk) begin
    if (adc_req && !prev_req) begin
      req_pulses <= req_pulses + 1;
      if (adc_chan == 2'd3) ch3_reqs <= ch3_reqs + 1;
    end
    if (adc_req && adc_chan == 2'd1) ch1_len <= ch1_len + 1;
    prev_req <= adc_req;
  end

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic adc_responder();
    int wait_cnt = 0;
    forever begin
      @(negedge clk);
      if (resp_en) begin
        adc_valid = 1'b0;
        if (!adc_req) begin
          wait_cnt = 0;
        end else if (!silent[adc_chan]) begin
          wait_cnt++;
          if (wait_cnt == resp_delay) begin
            adc_data  = vary ? 12'(seq * 37 + 5) : tab[adc_chan];
            seq++;
            n_valid++;
            adc_valid = 1'b1;
            if (mdl_cnt < FIFO_DEPTH) begin
              exp_q.push_back({adc_chan, adc_data});
              mdl_cnt++;
            end else begin
              exp_ovf = 1'b1;
            end
          end
        end
      end
    end
  endtask

  task automatic start_scan(input logic m, input logic [3:0] msk);
    @(negedge clk);
    mode = m; chan_mask = msk; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_idle(input int budget, input string tag);
    int i = 0;
    while (busy && i < budget) begin
      @(negedge clk);
      i++;
    end
    check_eq({tag, "_idle"}, busy, 0);
  endtask

  task automatic wait_req(input logic [1:0] ch, input int budget, input string tag);
    int i = 0;
    while (!(adc_req && adc_chan == ch) && i < budget) begin
      @(negedge clk);
      i++;
    end
    check_eq({tag, "_req"}, {adc_req, adc_chan}, {1'b1, ch});
  endtask

  // Pop the head; compare against the scoreboard, or a fixed value when given.
  task automatic pop_check(input string tag, input logic use_fixed, input logic [13:0] fixed);
    logic [13:0] e;
    e = '0;
    if (exp_q.size() > 0) e = exp_q.pop_front();
    if (use_fixed) e = fixed;
    check_eq({tag, "_ne"}, empty, 0);
    check_eq(tag, rd_data, e);
    rd_en = 1'b1;
    @(negedge clk);
    rd_en = 1'b0;
    mdl_cnt--;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int p0, c3, l1, n0, i;
    logic [13:0] e;
    rst_n = 1'b0; start = 1'b0; stop = 1'b0; mode = 1'b0; clr_flags = 1'b0;
    rd_en = 1'b0; chan_mask = 4'b0000; adc_valid = 1'b0; adc_data = 12'h000;
    tab[0] = 12'h111; tab[1] = 12'h123; tab[2] = 12'h222; tab[3] = 12'hABC;
    fork adc_responder(); join_none
    repeat (3) @(negedge clk);
    check_eq("rst_req", adc_req, 0);
    check_eq("rst_empty", empty, 1);
    check_eq("rst_level", level, 0);
    check_eq("rst_flags", {ovf, tout, full, busy}, 0);
    check_eq("rst_data", rd_data, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Single scan of ch1/ch3
    resp_en = 1'b1; resp_delay = 5;
    p0 = req_pulses;
    start_scan(1'b0, 4'b1010);
    check_eq("t1_lat0", adc_req, 0);
    @(negedge clk);
    check_eq("t1_lat1", {adc_req, adc_chan}, {1'b1, 2'd1});
    wait_idle(200, "t1");
    check_eq("t1_pulses", req_pulses - p0, 2);
    check_eq("t1_level", level, 2);
    pop_check("t1_pop0", 1'b1, {2'd1, 12'h123});
    pop_check("t1_pop1", 1'b1, {2'd3, 12'hABC});
    check_eq("t1_empty", empty, 1);
    rd_en = 1'b1;
    @(negedge clk);
    rd_en = 1'b0;
    @(negedge clk);
    check_eq("t1_rd_on_empty", {empty, level}, {1'b1, 5'd0});

    // Continuous scan of ch0 with no reads: overflow
    vary = 1'b1; resp_delay = 3;
    n0 = n_valid;
    start_scan(1'b1, 4'b0001);
    i = 0;
    while (n_valid - n0 < 20 && i < 1000) begin @(negedge clk); i++; end
    check_eq("t2_conversions", n_valid - n0 >= 20, 1);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    wait_idle(50, "t2");
    check_eq("t2_level", level, 16);
    check_eq("t2_full", full, 1);
    check_eq("t2_ovf", ovf, 1);
    check_eq("t2_exp_ovf", exp_ovf, 1);
    clr_flags = 1'b1;
    @(negedge clk);
    clr_flags = 1'b0;
    @(negedge clk);
    check_eq("t2_ovf_clr", ovf, 0);

    // Full FIFO with simultaneous read and write
    resp_en = 1'b0; vary = 1'b0;
    start_scan(1'b0, 4'b0001);
    wait_req(2'd0, 20, "t5");
    e = '0;
    if (exp_q.size() > 0) e = exp_q.pop_front();
    check_eq("t5_head", rd_data, e);
    exp_q.push_back({2'd0, 12'h5A5});
    adc_data = 12'h5A5; adc_valid = 1'b1; rd_en = 1'b1;
    @(negedge clk);
    adc_valid = 1'b0; rd_en = 1'b0;
    check_eq("t5_level", level, 16);
    check_eq("t5_full", full, 1);
    check_eq("t5_ovf", ovf, 0);
    wait_idle(20, "t5");
    for (int k = 0; k < 16; k++) pop_check("t5_drain", 1'b0, 14'h0);
    check_eq("t5_empty", empty, 1);
    mdl_cnt = 0; exp_ovf = 1'b0;

    // Continuous full-mask scan, stop during ch2
    resp_en = 1'b1; resp_delay = 5;
    c3 = ch3_reqs;
    start_scan(1'b1, 4'b1111);
    wait_req(2'd2, 200, "t4");
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    i = 0;
    while (adc_req && i < 50) begin @(negedge clk); i++; end
    check_eq("t4_req_drop", adc_req, 0);
    @(negedge clk);
    check_eq("t4_idle2", busy, 0);
    repeat (5) @(negedge clk);
    check_eq("t4_no_ch3", ch3_reqs - c3, 0);
    check_eq("t4_level", level, 3);
    pop_check("t4_pop0", 1'b1, {2'd0, 12'h111});
    pop_check("t4_pop1", 1'b1, {2'd1, 12'h123});
    pop_check("t4_pop2", 1'b1, {2'd2, 12'h222});

    // ch1 never answers: timeout, then ch2
    silent = 4'b0010;
    l1 = ch1_len;
    start_scan(1'b0, 4'b0110);
    wait_idle(TIMEOUT_CYC + 100, "t3");
    check_eq("t3_ch1_len", ch1_len - l1, TIMEOUT_CYC);
    check_eq("t3_tout", tout, 1);
    check_eq("t3_level", level, 1);
    check_eq("t3_head", rd_data, {2'd2, 12'h222});

    // Reset mid-conversion, then a zero-mask start
    resp_en = 1'b0; silent = 4'b0000;
    start_scan(1'b0, 4'b0001);
    wait_req(2'd0, 20, "t6");
    rst_n = 1'b0;
    @(negedge clk);
    check_eq("t6_req", adc_req, 0);
    check_eq("t6_empty", {empty, level}, {1'b1, 5'd0});
    check_eq("t6_flags", {ovf, tout, busy}, 0);
    exp_q.delete(); mdl_cnt = 0;
    rst_n = 1'b1;
    start_scan(1'b0, 4'b0000);
    repeat (3) @(negedge clk);
    check_eq("t6_zero_mask", {busy, adc_req}, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
